alu_seq: RTL and testbench

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 202 ++++++++++++++++++++
 tb/tb_alu_seq.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Sequential ALU with a valid/ready handshake. Shifts iterate one bit per cycle
// and multiply is shift-add over N cycles; the accept edge performs the first iteration.
module alu_seq #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [3:0]   sel,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] result,
   output logic [3:0]   flags,
   output logic         err
);
   localparam int SW = $clog2(N);
   localparam int CW = SW + 1;

   localparam logic [3:0] OP_NOT = 4'b0000;
   localparam logic [3:0] OP_AND = 4'b0001;
   localparam logic [3:0] OP_OR  = 4'b0010;
   localparam logic [3:0] OP_XOR = 4'b0011;
   localparam logic [3:0] OP_SHR = 4'b0100;
   localparam logic [3:0] OP_SHL = 4'b0101;
   localparam logic [3:0] OP_ASR = 4'b0110;
   localparam logic [3:0] OP_ROL = 4'b0111;
   localparam logic [3:0] OP_ADD = 4'b1000;
   localparam logic [3:0] OP_SUB = 4'b1001;
   localparam logic [3:0] OP_MUL = 4'b1010;
   localparam logic [3:0] OP_CMP = 4'b1011;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t         state;
   logic [3:0]     op_r;
   logic [N-1:0]   sh_r;
   logic [2*N-1:0] acc_r;
   logic [2*N-1:0] mc_r;
   logic [N-1:0]   mp_r;
   logic [CW-1:0]  cnt_r;

   logic [3:0]     cur_op;
   logic [N-1:0]   cur_sh;
   logic [2*N-1:0] cur_acc;
   logic [2*N-1:0] cur_mc;
   logic [N-1:0]   cur_mp;
   logic [CW-1:0]  cur_cnt;
   logic [N-1:0]   nxt_sh;
   logic [2*N-1:0] nxt_acc;
   logic           out_bit;
   logic           last;
   logic           multi;
   logic [N-1:0]   fin_result;
   logic [3:0]     fin_flags;

   logic [N:0]     sum;
   logic [N:0]     diff;
   logic [N-1:0]   sc_result;
   logic [N-1:0]   sc_zsrc;
   logic           sc_c;
   logic           sc_v;
   logic           sc_err;
   logic [3:0]     sc_flags;

   // Iteration datapath: in IDLE it works straight off the inputs so the accept edge
   // already performs iteration one; in BUSY it works off the saved registers.
   always_comb begin
      cur_op  = (state == IDLE) ? sel : op_r;
      cur_sh  = (state == IDLE) ? a : sh_r;
      cur_acc = (state == IDLE) ? '0 : acc_r;
      cur_mc  = (state == IDLE) ? {{N{1'b0}}, a} : mc_r;
      cur_mp  = (state == IDLE) ? b : mp_r;
      if (state == IDLE)
         cur_cnt = (sel == OP_MUL) ? CW'(N) : {1'b0, b[SW-1:0]};
      else
         cur_cnt = cnt_r;
      multi = (sel == OP_MUL) ||
              ((sel[3:2] == 2'b01) && (b[SW-1:0] != '0));

      nxt_sh  = cur_sh;
      out_bit = 1'b0;
      case (cur_op)
         OP_SHR: begin nxt_sh = {1'b0, cur_sh[N-1:1]};         out_bit = cur_sh[0];   end
         OP_SHL: begin nxt_sh = {cur_sh[N-2:0], 1'b0};         out_bit = cur_sh[N-1]; end
         OP_ASR: begin nxt_sh = {cur_sh[N-1], cur_sh[N-1:1]};  out_bit = cur_sh[0];   end
         OP_ROL: begin nxt_sh = {cur_sh[N-2:0], cur_sh[N-1]};  out_bit = 1'b0;        end
         default: ;
      endcase
      nxt_acc = cur_acc + (cur_mp[0] ? cur_mc : '0);
      last    = (cur_cnt == CW'(1));

      if (cur_op == OP_MUL) begin
         fin_result = nxt_acc[N-1:0];
         fin_flags  = {nxt_acc[N-1], nxt_acc[N-1:0] == '0, 1'b0, nxt_acc[2*N-1:N] != '0};
      end else begin
         fin_result = nxt_sh;
         fin_flags  = {nxt_sh[N-1], nxt_sh == '0, out_bit, 1'b0};
      end
   end

   always_comb begin
      sum       = {1'b0, a} + {1'b0, b};
      diff      = {1'b0, a} - {1'b0, b};
      sc_result = '0;
      sc_c      = 1'b0;
      sc_v      = 1'b0;
      sc_err    = 1'b0;
      case (sel)
         OP_NOT: sc_result = ~a;
         OP_AND: sc_result = a & b;
         OP_OR:  sc_result = a | b;
         OP_XOR: sc_result = a ^ b;
         OP_SHR, OP_SHL, OP_ASR, OP_ROL: sc_result = a;
         OP_ADD: begin
            sc_result = sum[N-1:0];
            sc_c      = sum[N];
            sc_v      = (a[N-1] == b[N-1]) && (sum[N-1] != a[N-1]);
         end
         OP_SUB, OP_CMP: begin
            sc_result = (sel == OP_CMP) ? a : diff[N-1:0];
            sc_c      = diff[N];
            sc_v      = (a[N-1] != b[N-1]) && (diff[N-1] != a[N-1]);
         end
         default: sc_err = 1'b1;
      endcase
      sc_zsrc  = (sel == OP_CMP) ? diff[N-1:0] : sc_result;
      sc_flags = sc_err ? 4'b0000 : {sc_zsrc[N-1], sc_zsrc == '0, sc_c, sc_v};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         result    <= '0;
         flags     <= '0;
         err       <= 1'b0;
         op_r      <= '0;
         sh_r      <= '0;
         acc_r     <= '0;
         mc_r      <= '0;
         mp_r      <= '0;
         cnt_r     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_ready <= 1'b0;
                  op_r     <= sel;
                  if (!multi) begin
                     result    <= sc_result;
                     flags     <= sc_flags;
                     err       <= sc_err;
                     out_valid <= 1'b1;
                     state     <= DONE;
                  end else begin
                     sh_r  <= nxt_sh;
                     acc_r <= nxt_acc;
                     mc_r  <= cur_mc << 1;
                     mp_r  <= cur_mp >> 1;
                     cnt_r <= cur_cnt - CW'(1);
                     if (last) begin
                        result    <= fin_result;
                        flags     <= fin_flags;
                        err       <= 1'b0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                     end else begin
                        state <= BUSY;
                     end
                  end
               end
            end
            BUSY: begin
               sh_r  <= nxt_sh;
               acc_r <= nxt_acc;
               mc_r  <= cur_mc << 1;
               mp_r  <= cur_mp >> 1;
               cnt_r <= cur_cnt - CW'(1);
               if (last) begin
                  result    <= fin_result;
                  flags     <= fin_flags;
                  err       <= 1'b0;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (N=4): vector table for every opcode class plus
// hand sequences for hold-in-DONE, throughput and reset priority.
module tb_alu_seq;
   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [3:0] a;
   logic [3:0] b;
   logic [3:0] sel;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] result;
   logic [3:0] flags;
   logic       err;

   int n_cmp = 0;
   int n_err = 0;

   alu_seq #(.N(4)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .flags(flags), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic [3:0] a;
      logic [3:0] b;
      logic [3:0] sel;
      logic [3:0] res;
      logic [3:0] flg;
      logic       e;
      int         lat;
   } vec_t;

   vec_t vecs[20];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Offers one op, then counts edges until out_valid (bounded).
   task automatic run_op(input logic [3:0] ta, input logic [3:0] tb, input logic [3:0] ts,
                         output int lat);
      @(negedge clk);
      a = ta; b = tb; sel = ts; in_valid = 1'b1; out_ready = 1'b0;
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic release_result(input string nm);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk({nm, ".in_ready_after"}, 32'(in_ready), 32'd1);
      chk({nm, ".out_valid_after"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int lat;

      vecs[0]  = '{"add_ovf",   4'b0111, 4'b0001, 4'b1000, 4'b1000, 4'b1001, 1'b0, 1};
      vecs[1]  = '{"sub_borrow",4'b0000, 4'b0001, 4'b1001, 4'b1111, 4'b1010, 1'b0, 1};
      vecs[2]  = '{"sub_zero",  4'b0001, 4'b0001, 4'b1001, 4'b0000, 4'b0100, 1'b0, 1};
      vecs[3]  = '{"shl3",      4'b1001, 4'b0011, 4'b0101, 4'b1000, 4'b1000, 1'b0, 3};
      vecs[4]  = '{"asr1",      4'b1001, 4'b0001, 4'b0110, 4'b1100, 4'b1010, 1'b0, 1};
      vecs[5]  = '{"mul_3x5",   4'b0011, 4'b0101, 4'b1010, 4'b1111, 4'b1000, 1'b0, 4};
      vecs[6]  = '{"mul_4x4",   4'b0100, 4'b0100, 4'b1010, 4'b0000, 4'b0101, 1'b0, 4};
      vecs[7]  = '{"not",       4'b1010, 4'b0000, 4'b0000, 4'b0101, 4'b0000, 1'b0, 1};
      vecs[8]  = '{"or",        4'b1000, 4'b0001, 4'b0010, 4'b1001, 4'b1000, 1'b0, 1};
      vecs[9]  = '{"xor_zero",  4'b1111, 4'b1111, 4'b0011, 4'b0000, 4'b0100, 1'b0, 1};
      vecs[10] = '{"add_carry", 4'b1111, 4'b0001, 4'b1000, 4'b0000, 4'b0110, 1'b0, 1};
      vecs[11] = '{"cmp",       4'b0011, 4'b0101, 4'b1011, 4'b0011, 4'b1010, 1'b0, 1};
      vecs[12] = '{"shr2",      4'b1011, 4'b0010, 4'b0100, 4'b0010, 4'b0010, 1'b0, 2};
      vecs[13] = '{"rol1",      4'b1001, 4'b0001, 4'b0111, 4'b0011, 4'b0000, 1'b0, 1};
      vecs[14] = '{"shl_amt0",  4'b1001, 4'b0100, 4'b0101, 4'b1001, 4'b1000, 1'b0, 1};
      vecs[15] = '{"illegal",   4'b1111, 4'b1111, 4'b1100, 4'b0000, 4'b0000, 1'b1, 1};
      vecs[16] = '{"asr3",      4'b1000, 4'b0011, 4'b0110, 4'b1111, 4'b1000, 1'b0, 3};
      vecs[17] = '{"mul_15x15", 4'b1111, 4'b1111, 4'b1010, 4'b0001, 4'b0001, 1'b0, 4};
      vecs[18] = '{"sub_ovf",   4'b1000, 4'b0001, 4'b1001, 4'b0111, 4'b0001, 1'b0, 1};
      vecs[19] = '{"add_all",   4'b1000, 4'b1000, 4'b1000, 4'b0000, 4'b0111, 1'b0, 1};

      rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; sel = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset.in_ready", 32'(in_ready), 32'd1);
      chk("reset.out_valid", 32'(out_valid), 32'd0);
      chk("reset.result", 32'(result), 32'd0);
      chk("reset.flags", 32'(flags), 32'd0);
      chk("reset.err", 32'(err), 32'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int unsigned i = 0; i < 20; i++) begin
         run_op(vecs[i].a, vecs[i].b, vecs[i].sel, lat);
         chk({vecs[i].name, ".latency"}, 32'(lat), 32'(vecs[i].lat));
         chk({vecs[i].name, ".result"}, 32'(result), 32'(vecs[i].res));
         chk({vecs[i].name, ".flags"}, 32'(flags), 32'(vecs[i].flg));
         chk({vecs[i].name, ".err"}, 32'(err), 32'(vecs[i].e));
         release_result(vecs[i].name);
      end

      // Result must hold while stalled in DONE, ignoring new offers.
      run_op(4'b0111, 4'b0001, 4'b1000, lat);
      for (int unsigned k = 0; k < 5; k++) begin
         @(negedge clk);
         in_valid = ~in_valid;
         a = a + 4'd3;
         sel = sel ^ 4'b0011;
         @(posedge clk); #1;
         chk("hold.result", 32'(result), 32'b1000);
         chk("hold.flags", 32'(flags), 32'b1001);
         chk("hold.err", 32'(err), 32'd0);
         chk("hold.in_ready", 32'(in_ready), 32'd0);
         chk("hold.out_valid", 32'(out_valid), 32'd1);
      end

      // in_valid held through the release edge: no accept until back in IDLE.
      @(negedge clk);
      a = 4'b0001; b = 4'b0001; sel = 4'b1000; in_valid = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      chk("b2b.out_valid", 32'(out_valid), 32'd0);
      chk("b2b.in_ready", 32'(in_ready), 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b0;
      chk("b2b.accept_valid", 32'(out_valid), 32'd1);
      chk("b2b.result", 32'(result), 32'b0010);
      chk("b2b.flags", 32'(flags), 32'b0000);
      release_result("b2b");

      // Reset in the second BUSY cycle of a multiply.
      @(negedge clk);
      a = 4'b0011; b = 4'b0101; sel = 4'b1010; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("rstmul.busy1_ready", 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      chk("rstmul.busy2_valid", 32'(out_valid), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rstmul.in_ready", 32'(in_ready), 32'd1);
      chk("rstmul.out_valid", 32'(out_valid), 32'd0);
      chk("rstmul.result", 32'(result), 32'd0);
      repeat (4) @(posedge clk);
      #1;
      chk("rstmul.no_stale", 32'(out_valid), 32'd0);

      run_op(4'b1100, 4'b1010, 4'b0001, lat);
      chk("and.latency", 32'(lat), 32'd1);
      chk("and.result", 32'(result), 32'b1000);
      chk("and.flags", 32'(flags), 32'b1000);
      release_result("and");

      run_op(4'b1100, 4'b1010, 4'b1111, lat);
      chk("ill15.err", 32'(err), 32'd1);
      chk("ill15.result", 32'(result), 32'd0);
      chk("ill15.flags", 32'(flags), 32'd0);

      // Reset beats both out_ready and a pending offer while in DONE.
      @(negedge clk);
      rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1; a = 4'b0111; b = 4'b0001; sel = 4'b1000;
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b0; in_valid = 1'b0;
      chk("rstdone.err", 32'(err), 32'd0);
      chk("rstdone.out_valid", 32'(out_valid), 32'd0);
      chk("rstdone.in_ready", 32'(in_ready), 32'd1);
      chk("rstdone.result", 32'(result), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
